// File: rtl/mul_tile_sched.sv
// mul_tile_sched: tile scheduler for a SYSTOLIC_WIDTH x SYSTOLIC_WIDTH systolic
// multiplier. Each tile runs LOAD (SYSTOLIC_WIDTH read beats), COMP
// (2*SYSTOLIC_WIDTH-1 cycles), then DRAIN (SYSTOLIC_WIDTH write beats).
// Optional feature macro: MUL_SCHED_PERF_CNT_EN enables the stall_cnt counter;
// without it stall_cnt is a constant zero.
module mul_tile_sched #(
  parameter int SYSTOLIC_WIDTH = 4,
  parameter int TILE_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode_in,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              src_valid,
  input  logic              wr_ready,
  output logic              rd_en,
  output logic              wr_en,
  output logic              systolic_state,
  output logic              systolic_mode,
  output logic              transposition_slect,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cnt
);

  localparam int COMP_CYCLES = 2 * SYSTOLIC_WIDTH - 1;
  localparam int CNT_W       = $clog2(COMP_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(SYSTOLIC_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_COMP = CNT_W'(COMP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    COMP  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
  logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
  logic              systolic_mode_q, systolic_mode_d;
  logic              transposition_slect_q, transposition_slect_d;

  // Next-state and output decode; abort overrides every transition and strobe.
  always_comb begin
    state_d               = state_q;
    cnt_d                 = cnt_q;
    tile_idx_d            = tile_idx_q;
    num_tiles_d           = num_tiles_q;
    systolic_mode_d       = systolic_mode_q;
    transposition_slect_d = transposition_slect_q;
    rd_en                 = 1'b0;
    wr_en                 = 1'b0;
    done                  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          num_tiles_d           = num_tiles;
          systolic_mode_d       = mode_in;
          tile_idx_d            = '0;
          transposition_slect_d = 1'b0;
          state_d               = (num_tiles == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        rd_en = src_valid;
        if (src_valid) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = COMP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      COMP: begin
        if (cnt_q == LAST_COMP) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        wr_en = wr_ready;
        if (wr_ready) begin
          if (cnt_q == LAST_BEAT) begin
            if (tile_idx_q == num_tiles_q - TILE_W'(1)) begin
              state_d = DONE;
            end else begin
              tile_idx_d            = tile_idx_q + TILE_W'(1);
              transposition_slect_d = ~transposition_slect_q;
              state_d               = LOAD;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d               = IDLE;
      rd_en                 = 1'b0;
      wr_en                 = 1'b0;
      done                  = 1'b0;
      tile_idx_d            = tile_idx_q;
      transposition_slect_d = transposition_slect_q;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // State, counter and job-context registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= IDLE;
      cnt_q                 <= '0;
      tile_idx_q            <= '0;
      num_tiles_q           <= '0;
      systolic_mode_q       <= 1'b0;
      transposition_slect_q <= 1'b0;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      tile_idx_q            <= tile_idx_d;
      num_tiles_q           <= num_tiles_d;
      systolic_mode_q       <= systolic_mode_d;
      transposition_slect_q <= transposition_slect_d;
    end
  end

  assign systolic_state      = (state_q == COMP);
  assign busy                = (state_q != IDLE);
  assign systolic_mode       = systolic_mode_q;
  assign transposition_slect = transposition_slect_q;
  assign tile_idx            = tile_idx_q;

`ifdef MUL_SCHED_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles spent waiting on memory in LOAD or DRAIN.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == IDLE) && start && !abort) begin
      stall_cnt_d = '0;
    end else if (!abort && (stall_cnt_q != 32'hFFFF_FFFF) &&
                 (((state_q == LOAD) && !src_valid) ||
                  ((state_q == DRAIN) && !wr_ready))) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_tile_sched.sv
// tb_mul_tile_sched: self-checking bench for mul_tile_sched. A queue-of-steps
// reference model predicts every output each cycle; directed jobs add
// whole-job checks on timing and beat counts. Honours MUL_SCHED_PERF_CNT_EN.
module tb_mul_tile_sched;

  localparam int SW     = 4;
  localparam int TILE_W = 16;
  localparam int COMP_N = 2 * SW - 1;

  logic              clk = 1'b0;
  logic              rst, start, abort, mode_in, src_valid, wr_ready;
  logic [TILE_W-1:0] num_tiles;
  logic              rd_en, wr_en, systolic_state, systolic_mode;
  logic              transposition_slect, busy, done;
  logic [TILE_W-1:0] tile_idx;
  logic [31:0]       stall_cnt;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit check_en     = 1'b0;

  mul_tile_sched #(.SYSTOLIC_WIDTH(SW), .TILE_W(TILE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_in(mode_in),
    .num_tiles(num_tiles), .src_valid(src_valid), .wr_ready(wr_ready),
    .rd_en(rd_en), .wr_en(wr_en), .systolic_state(systolic_state),
    .systolic_mode(systolic_mode), .transposition_slect(transposition_slect),
    .tile_idx(tile_idx), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference model: a job is a list of steps; LOAD/DRAIN steps retire only
  // when memory cooperates, COMP and DONE steps retire every cycle.
  localparam int K_LOAD = 0, K_COMP = 1, K_DRAIN = 2, K_DONE = 3;
  typedef struct { int kind; int tile; } step_t;
  step_t       plan[$];
  int          m_tile_hold = 0;
  bit          m_mode      = 1'b0;
  logic [31:0] m_stall     = '0;

  // Advance the model on each rising edge using the inputs of the ending cycle.
  always @(posedge clk) begin
    if (rst) begin
      plan.delete();
      m_tile_hold = 0;
      m_mode      = 1'b0;
      m_stall     = '0;
    end else if (plan.size() == 0) begin
      if (start && !abort) begin
        m_mode      = mode_in;
        m_tile_hold = 0;
        m_stall     = '0;
        for (int t = 0; t < int'(num_tiles); t++) begin
          for (int b = 0; b < SW; b++)     plan.push_back('{K_LOAD, t});
          for (int c = 0; c < COMP_N; c++) plan.push_back('{K_COMP, t});
          for (int b = 0; b < SW; b++)     plan.push_back('{K_DRAIN, t});
        end
        plan.push_back('{K_DONE, (num_tiles == 0) ? 0 : int'(num_tiles) - 1});
      end
    end else if (abort) begin
      m_tile_hold = plan[0].tile;
      plan.delete();
    end else begin
      m_tile_hold = plan[0].tile;
`ifdef MUL_SCHED_PERF_CNT_EN
      if (((plan[0].kind == K_LOAD) && !src_valid) || ((plan[0].kind == K_DRAIN) && !wr_ready))
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
      if (((plan[0].kind == K_LOAD) && src_valid) || (plan[0].kind == K_COMP) ||
          ((plan[0].kind == K_DRAIN) && wr_ready) || (plan[0].kind == K_DONE))
        void'(plan.pop_front());
    end
  end

  // Compare every DUT output with the model mid-cycle.
  always @(negedge clk) begin
    int k, e_tile;
    if (check_en) begin
      if (plan.size() > 0) begin k = plan[0].kind; e_tile = plan[0].tile; end
      else begin k = -1; e_tile = m_tile_hold; end
      checkOutput("rd_en", 32'(rd_en), 32'((k == K_LOAD) && src_valid && !abort));
      checkOutput("wr_en", 32'(wr_en), 32'((k == K_DRAIN) && wr_ready && !abort));
      checkOutput("systolic_state", 32'(systolic_state), 32'(k == K_COMP));
      checkOutput("busy", 32'(busy), 32'(k != -1));
      checkOutput("done", 32'(done), 32'((k == K_DONE) && !abort));
      checkOutput("tile_idx", 32'(tile_idx), 32'(e_tile));
      checkOutput("transposition_slect", 32'(transposition_slect), 32'(e_tile & 1));
      checkOutput("systolic_mode", 32'(systolic_mode), 32'(m_mode));
      checkOutput("stall_cnt", stall_cnt, m_stall);
    end
  end

  // Global time limit so the bench always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input bit st, input bit ab, input bit md, input int nt,
                               input bit sv, input bit wr, input bit rs);
    start     = st;
    abort     = ab;
    mode_in   = md;
    num_tiles = nt[TILE_W-1:0];
    src_valid = sv;
    wr_ready  = wr;
    rst       = rs;
  endtask

  int ev_abort_at, ev_restart_at, ev_rst_at, ev_sv_lo, ev_sv_hi, ev_wr_lo, ev_wr_hi;
  int r_cycles, r_rd, r_wr, r_comp, r_tile, r_busy;
  bit r_done, r_mode, r_aborted;
  logic [31:0] r_stall;

  task automatic clearEvents();
    ev_abort_at = -1; ev_restart_at = -1; ev_rst_at = -1;
    ev_sv_lo = -1; ev_sv_hi = -1; ev_wr_lo = -1; ev_wr_hi = -1;
  endtask

  // Run one job; cycle 1 is the first cycle after the start edge.
  task automatic runJob(input int nt, input bit md, input int sv_pct, input int wr_pct, input int max_cyc);
    int  n;
    bit  sv, wr;
    r_rd = 0; r_wr = 0; r_comp = 0; r_done = 0; r_aborted = 0;
    applyStimulus(1'b1, 1'b0, md, nt, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    n = 1;
    forever begin
      sv = !((n >= ev_sv_lo) && (n <= ev_sv_hi)) && ($urandom_range(0, 99) < sv_pct);
      wr = !((n >= ev_wr_lo) && (n <= ev_wr_hi)) && ($urandom_range(0, 99) < wr_pct);
      applyStimulus(n == ev_restart_at, n == ev_abort_at, ~md,
                    ((ev_restart_at > 0) && (n >= ev_restart_at)) ? 5 : nt,
                    sv, wr, n == ev_rst_at);
      @(negedge clk);
      r_rd   += int'(rd_en);
      r_wr   += int'(wr_en);
      r_comp += int'(systolic_state);
      if (done) r_done = 1'b1;
      r_stall = stall_cnt;
      r_mode  = systolic_mode;
      r_tile  = int'(tile_idx);
      r_busy  = int'(busy);
      if (done || (r_aborted && !busy)) break;
      if ((n == ev_abort_at) || (n == ev_rst_at)) r_aborted = 1'b1;
      if (n >= max_cyc) begin
        checkOutput("job_timeout", 32'(n), 32'(max_cyc + 1));
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    r_cycles = n;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    clearEvents();
  endtask

  initial begin
    int nt;
    clearEvents();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset tile_idx", 32'(tile_idx), 32'd0);
    checkOutput("reset stall_cnt", stall_cnt, 32'd0);
    @(posedge clk); #1;

    // Two tiles, output-stationary, no stalls.
    runJob(2, 1'b1, 100, 100, 100);
    checkOutput("two tiles done cycle", 32'(r_cycles), 32'd31);
    checkOutput("two tiles rd beats", 32'(r_rd), 32'd8);
    checkOutput("two tiles wr beats", 32'(r_wr), 32'd8);
    checkOutput("two tiles comp cycles", 32'(r_comp), 32'd14);
    checkOutput("two tiles mode", 32'(r_mode), 32'd1);

    // Empty job.
    runJob(0, 1'b0, 100, 100, 20);
    checkOutput("zero tiles done cycle", 32'(r_cycles), 32'd1);
    checkOutput("zero tiles rd+wr", 32'(r_rd + r_wr), 32'd0);

    // Single tile with three read stalls and two write stalls.
    ev_sv_lo = 1; ev_sv_hi = 3; ev_wr_lo = 15; ev_wr_hi = 16;
    runJob(1, 1'b0, 100, 100, 60);
    checkOutput("stalled tile done cycle", 32'(r_cycles), 32'd21);
    checkOutput("stalled tile rd beats", 32'(r_rd), 32'd4);
    checkOutput("stalled tile wr beats", 32'(r_wr), 32'd4);
`ifdef MUL_SCHED_PERF_CNT_EN
    checkOutput("stalled tile stall_cnt", r_stall, 32'd5);
`else
    checkOutput("stalled tile stall_cnt", r_stall, 32'd0);
`endif

    // Abort in the third COMP cycle of tile 1, then a full three-tile job.
    ev_abort_at = 22;
    runJob(3, 1'b0, 100, 100, 80);
    checkOutput("abort no done", 32'(r_done), 32'd0);
    checkOutput("abort tile_idx held", 32'(r_tile), 32'd1);
    checkOutput("abort busy", 32'(r_busy), 32'd0);
    runJob(3, 1'b1, 100, 100, 80);
    checkOutput("after abort done cycle", 32'(r_cycles), 32'd46);
    checkOutput("after abort rd beats", 32'(r_rd), 32'd12);

    // Second start during DRAIN with a larger tile count is ignored.
    ev_restart_at = 13;
    runJob(1, 1'b0, 100, 100, 60);
    checkOutput("restart ignored done cycle", 32'(r_cycles), 32'd16);
    checkOutput("restart ignored wr beats", 32'(r_wr), 32'd4);

    // Reset on LOAD beat 2, then a fresh job.
    ev_rst_at = 2;
    runJob(2, 1'b1, 100, 100, 60);
    checkOutput("mid-job reset no done", 32'(r_done), 32'd0);
    checkOutput("mid-job reset mode", 32'(r_mode), 32'd0);
    checkOutput("mid-job reset tile_idx", 32'(r_tile), 32'd0);
    runJob(1, 1'b0, 100, 100, 60);
    checkOutput("post-reset done cycle", 32'(r_cycles), 32'd16);

    // Randomised jobs with random memory back-pressure and occasional abort.
    for (int j = 0; j < 12; j++) begin
      nt = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) ev_abort_at = $urandom_range(1, 40);
      runJob(nt, 1'($urandom_range(0, 1)), $urandom_range(40, 100), $urandom_range(40, 100), 600);
      if (!r_aborted) begin
        checkOutput("random rd beats", 32'(r_rd), 32'(SW * nt));
        checkOutput("random wr beats", 32'(r_wr), 32'(SW * nt));
        checkOutput("random comp cycles", 32'(r_comp), 32'(COMP_N * nt));
      end
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mul_tile_sched.md
MUL_TILE_SCHED -- requirements
Module: mul_tile_sched

Interface
REQ-001 SHALL have parameter SYSTOLIC_WIDTH, default 4, array dimension and beats per load/drain phase.
REQ-002 SHALL have parameter TILE_W, default 16, width of the tile-count and tile-index fields.
REQ-003 SHALL have localparam COMP_CYCLES = 2*SYSTOLIC_WIDTH-1, compute-phase length in cycles.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin a job; sampled only in IDLE.
REQ-007 abort  input  1  cancel the current job.
REQ-008 mode_in  input  1  systolic mode for the job: 0 weight-stationary, 1 output-stationary.
REQ-009 num_tiles  input  TILE_W  tiles in the job.
REQ-010 src_valid  input  1  memory read data available this cycle.
REQ-011 wr_ready  input  1  write-back port accepts data this cycle.
REQ-012 rd_en  output  1  read beat taken.
REQ-013 wr_en  output  1  write beat issued.
REQ-014 systolic_state  output  1  0 transfer, 1 compute.
REQ-015 systolic_mode  output  1  latched mode_in.
REQ-016 transposition_slect  output  1  transposer ping-pong select.
REQ-017 tile_idx  output  TILE_W  current tile index.
REQ-018 busy  output  1  high in any state except IDLE.
REQ-019 done  output  1  one-cycle job-complete pulse.
REQ-020 stall_cnt  output  32  stall-cycle counter (see Configuration).

Function
REQ-021 FSM states SHALL be IDLE, LOAD, COMP, DRAIN and DONE.
- IDLE: on start=1, latch num_tiles and mode_in, clear tile_idx, go to LOAD; if latched num_tiles=0, go to DONE instead.
- LOAD: rd_en = src_valid (combinational); beat counter increments on rd_en; after the SYSTOLIC_WIDTH-th beat, go to COMP next cycle.
- COMP: systolic_state=1 for exactly COMP_CYCLES cycles, then DRAIN; rd_en=wr_en=0.
- DRAIN: wr_en = wr_ready; beat counter increments on wr_en; after the SYSTOLIC_WIDTH-th beat: if tile_idx = num_tiles-1, go to DONE; otherwise increment tile_idx, toggle transposition_slect and go to LOAD.
- DONE: done=1 for one cycle, then IDLE.
REQ-022 systolic_state SHALL be 0 in every state except COMP.
REQ-023 start received while busy SHALL be ignored; num_tiles and mode_in changes after latch SHALL have no effect.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE on the next cycle.
- Same cycle: rd_en and wr_en forced 0.
- done not pulsed.
- abort has priority over every other transition.
REQ-025 start and abort both high in IDLE: start SHALL be ignored.
REQ-026 Beat and compute counters SHALL clear on every state entry.
REQ-027 tile_idx SHALL never exceed num_tiles-1 and SHALL hold its value in IDLE after a job ends.
REQ-028 Latency, start to first rd_en opportunity, SHALL be 1 cycle.
REQ-029 With src_valid=wr_ready=1, a tile SHALL take exactly 2*SYSTOLIC_WIDTH+COMP_CYCLES cycles.
REQ-030 transposition_slect SHALL reset to 0 at each job start.

Reset
REQ-031 rst=1 SHALL, on the next edge, force IDLE and drive these values regardless of state:
- rd_en=0, wr_en=0, systolic_state=0, systolic_mode=0, transposition_slect=0, tile_idx=0, busy=0, done=0, stall_cnt=0.
- All internal counters cleared.
REQ-032 Reset asserted mid-job SHALL discard the job without a done pulse.

Configuration
REQ-033 Macro MUL_SCHED_PERF_CNT_EN, when defined, SHALL enable stall_cnt.
- Increments by 1 per cycle in LOAD with src_valid=0 or in DRAIN with wr_ready=0.
- Saturates at 32'hFFFFFFFF.
- Clears at job start.
REQ-034 Without MUL_SCHED_PERF_CNT_EN, stall_cnt SHALL be tied to 0 and no counter logic SHALL be synthesised; the port SHALL remain.

Verification
REQ-035 num_tiles=2, mode_in=1, src_valid=wr_ready=1:
- 4 rd_en, 7 cycles systolic_state=1, 4 wr_en per tile.
- transposition_slect 0 then 1.
- done pulses 31 cycles after the start edge (1 + 2 tiles x 15).
- systolic_mode=1 throughout.
REQ-036 num_tiles=0, start=1: busy for the DONE cycle only, done pulses 1 cycle later, zero rd_en/wr_en.
REQ-037 num_tiles=1, src_valid low for 3 cycles during LOAD, wr_ready low 2 cycles during DRAIN:
- Exactly 4 rd_en and 4 wr_en.
- Tile takes 20 cycles.
- With MUL_SCHED_PERF_CNT_EN, stall_cnt=5; without it, stall_cnt=0.
REQ-038 abort asserted in cycle 3 of COMP of tile 1 (num_tiles=3): IDLE next cycle, no done, tile_idx holds 1; a following start runs 3 full tiles.
REQ-039 start pulsed again during DRAIN with num_tiles changed from 1 to 5: ignored; job ends after 1 tile.
REQ-040 rst asserted in LOAD beat 2: all outputs at reset values next cycle, no done, next start behaves as from power-on.
